seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serial pattern generator. Captures a pattern, a bit length
//                and a repeat count on an accepted start, then shifts the
//                pattern out MSB-first, one bit per cycle, repeating it with
//                a single idle gap cycle between repetitions.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       rpt,
  output logic             ready,
  output logic             w,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] idx_q,   idx_d;   // index of the bit currently on w
  logic [3:0]       rpt_q,   rpt_d;   // repetitions still to send
  logic             w_q,     w_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;
  logic [LEN_W-1:0] len_eff;

  // Select one bit of a pattern; shifting keeps the index width independent
  // of WIDTH, since the length field may be wider than a bit index needs.
  function automatic logic bit_at(input logic [WIDTH-1:0] v,
                                  input logic [LEN_W-1:0] i);
    logic [WIDTH-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Out-of-range or zero lengths send the full pattern width
  assign len_eff = ((len == '0) || (len > WIDTH_L)) ? WIDTH_L : len;

  // Next-state and next-output logic; data outputs are registered so the
  // first bit appears the cycle after the accepting edge.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rpt_d   = rpt_q;
    w_d     = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          pat_d   = pattern;
          len_d   = len_eff;
          rpt_d   = rpt;
          idx_d   = len_eff - 1'b1;
          w_d     = bit_at(pattern, len_eff - 1'b1);
          valid_d = 1'b1;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d   = idx_q - 1'b1;
          w_d     = bit_at(pat_q, idx_q - 1'b1);
          valid_d = 1'b1;
        end else if (rpt_q != 4'd0) begin
          // Last bit of a repetition with more to come: one gap cycle
          state_d = GAP;
          rpt_d   = rpt_q - 4'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        state_d = SHIFT;
        idx_d   = len_q - 1'b1;
        w_d     = bit_at(pat_q, len_q - 1'b1);
        valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rpt_q   <= 4'd0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rpt_q   <= rpt_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign w     = w_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule
`default_nettype wire
